// File: rtl/wb_regfile_if.sv
// Writeback / operand-read / issue bundle between the pipeline and wb_regfile.
interface wb_regfile_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            WB_EN;
  logic [AW-1:0]   WB_ADDR;
  logic [XLEN-1:0] WB_DATA;
  logic [AW-1:0]   RS1_ADDR;
  logic [AW-1:0]   RS2_ADDR;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic            ISSUE_REQ;
  logic [AW-1:0]   RD;
  logic            STALL;

  modport master (
    output WB_EN, WB_ADDR, WB_DATA, RS1_ADDR, RS2_ADDR, ISSUE_REQ, RD,
    input  RS1, RS2, STALL
  );

  modport slave (
    input  WB_EN, WB_ADDR, WB_DATA, RS1_ADDR, RS2_ADDR, ISSUE_REQ, RD,
    output RS1, RS2, STALL
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback register file with registered operand reads and a busy scoreboard.
// Optional macro WB_REGFILE_BYPASS_EN forwards same-edge writebacks to reads and stall.
module wb_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input logic         clock,
  input logic         reset,
  wb_regfile_if.slave bus
);
  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic            wb_we;
  logic            src1_busy, src2_busy;
  logic            stall;

  assign wb_we = bus.WB_EN && (bus.WB_ADDR != '0);

`ifdef WB_REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1 = wb_we && (bus.WB_ADDR == bus.RS1_ADDR);
  assign fwd2 = wb_we && (bus.WB_ADDR == bus.RS2_ADDR);
`endif

  always_comb begin
    rs1_d = (bus.RS1_ADDR == '0) ? '0 : rf_q[bus.RS1_ADDR];
    rs2_d = (bus.RS2_ADDR == '0) ? '0 : rf_q[bus.RS2_ADDR];
`ifdef WB_REGFILE_BYPASS_EN
    if (fwd1) rs1_d = bus.WB_DATA;
    if (fwd2) rs2_d = bus.WB_DATA;
`endif
  end

  // Only source operands may be relaxed by forwarding; RD always waits for busy to clear.
  always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
    src1_busy = busy_q[bus.RS1_ADDR] & ~fwd1;
    src2_busy = busy_q[bus.RS2_ADDR] & ~fwd2;
`else
    src1_busy = busy_q[bus.RS1_ADDR];
    src2_busy = busy_q[bus.RS2_ADDR];
`endif
    stall = bus.ISSUE_REQ & (src1_busy | src2_busy | busy_q[bus.RD]);
  end

  always_comb begin
    busy_d = busy_q;
    if (wb_we) busy_d[bus.WB_ADDR] = 1'b0;
    if (bus.ISSUE_REQ && !stall && (bus.RD != '0)) busy_d[bus.RD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      busy_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      if (wb_we) rf_q[bus.WB_ADDR] <= bus.WB_DATA;
      busy_q <= busy_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
    end
  end

  assign bus.RS1   = rs1_q;
  assign bus.RS2   = rs2_q;
  assign bus.STALL = stall;
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile; honours WB_REGFILE_BYPASS_EN when defined.
module tb_wb_regfile;
`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];
  exp_t e;

  wb_regfile_if #(.NREG(32), .XLEN(32)) bus ();

  wb_regfile #(.NREG(32), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.WB_EN = 1'b0; bus.WB_ADDR = '0; bus.WB_DATA = '0;
    bus.RS1_ADDR = '0; bus.RS2_ADDR = '0;
    bus.ISSUE_REQ = 1'b0; bus.RD = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.RS1 !== 32'h0 || bus.RS2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rs: RS1=%h RS2=%h required 0 0", bus.RS1, bus.RS2);
    end
    n_tests++;
    if (bus.STALL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: STALL=%b required 0", bus.STALL);
    end
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd5; bus.WB_DATA = 32'h0000_0011;
    bus.RS1_ADDR = 5'd5; bus.RS2_ADDR = 5'd0;
    sbq.push_back('{BYP ? 32'h11 : 32'h0, 32'h0});
    step();
    bus.WB_EN = 1'b0;
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1) begin
      n_fail++;
      $display("FAIL wr_same_edge_rs1: got %h required %h", bus.RS1, e.rs1);
    end
    sbq.push_back('{32'h11, 32'h0});
    step();
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL wr_read_r5: got %h/%h required %h/%h", bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
  endtask

  task automatic test_r0();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd0; bus.WB_DATA = 32'hFFFF_FFFF;
    bus.RS1_ADDR = 5'd0; bus.RS2_ADDR = 5'd0;
    sbq.push_back('{32'h0, 32'h0});
    step();
    bus.WB_EN = 1'b0;
    sbq.push_back('{32'h0, 32'h0});
    step();
    for (int k = 0; k < 2; k++) begin
      e = sbq.pop_front();
      n_tests++;
      if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
        n_fail++;
        $display("FAIL r0_read[%0d]: got %h/%h required %h/%h", k, bus.RS1, bus.RS2, e.rs1, e.rs2);
      end
    end
    // Issue to r0 must not mark it busy, so a second r0 issue does not stall.
    bus.ISSUE_REQ = 1'b1; bus.RD = 5'd0;
    step();
    n_tests++;
    if (bus.STALL !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_busy: STALL=%b required 0", bus.STALL);
    end
    bus.ISSUE_REQ = 1'b0;
  endtask

  task automatic test_stall();
    bus.ISSUE_REQ = 1'b1; bus.RD = 5'd3; bus.RS1_ADDR = 5'd1; bus.RS2_ADDR = 5'd2;
    #1;
    n_tests++;
    if (bus.STALL !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_first_issue: STALL=%b required 0", bus.STALL);
    end
    step();
    bus.RD = 5'd0; bus.RS1_ADDR = 5'd3; bus.RS2_ADDR = 5'd0;
    #1;
    n_tests++;
    if (bus.STALL !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_raw: STALL=%b required 1", bus.STALL);
    end
    step();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd3; bus.WB_DATA = 32'h5;
    sbq.push_back('{BYP ? 32'h5 : 32'h0, 32'h0});
    #1;
    n_tests++;
    if (bus.STALL !== !BYP) begin
      n_fail++;
      $display("FAIL stall_wb_cycle: STALL=%b required %b", bus.STALL, !BYP);
    end
    step();
    bus.WB_EN = 1'b0;
    e = sbq.pop_front();
    n_tests++;
    if (bus.STALL !== 1'b0 || bus.RS1 !== e.rs1) begin
      n_fail++;
      $display("FAIL stall_after_wb: STALL=%b RS1=%h required 0 %h", bus.STALL, bus.RS1, e.rs1);
    end
    bus.ISSUE_REQ = 1'b0;
    sbq.push_back('{32'h5, 32'h0});
    step();
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1) begin
      n_fail++;
      $display("FAIL stall_r3_value: RS1=%h required %h", bus.RS1, e.rs1);
    end
  endtask

  task automatic test_bypass();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd7; bus.WB_DATA = 32'h2;
    bus.RS1_ADDR = 5'd5; bus.RS2_ADDR = 5'd0;
    step();
    bus.WB_DATA = 32'hA; bus.RS2_ADDR = 5'd7;
    sbq.push_back('{32'h11, BYP ? 32'hA : 32'h2});
    step();
    bus.WB_EN = 1'b0;
    sbq.push_back('{32'h11, 32'hA});
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL bypass_same_edge: got %h/%h required %h/%h", bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
    step();
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL bypass_next_edge: got %h/%h required %h/%h", bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
  endtask

  task automatic test_reissue();
    bus.ISSUE_REQ = 1'b1; bus.RD = 5'd4; bus.RS1_ADDR = 5'd0; bus.RS2_ADDR = 5'd0;
    step();
    n_tests++;
    if (bus.STALL !== 1'b1) begin
      n_fail++;
      $display("FAIL reissue_busy: STALL=%b required 1", bus.STALL);
    end
    step();
    n_tests++;
    if (bus.STALL !== 1'b1) begin
      n_fail++;
      $display("FAIL reissue_hold: STALL=%b required 1", bus.STALL);
    end
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd4; bus.WB_DATA = 32'h44;
    #1;
    n_tests++;
    if (bus.STALL !== 1'b1) begin
      n_fail++;
      $display("FAIL reissue_rd_not_relaxed: STALL=%b required 1", bus.STALL);
    end
    step();
    bus.WB_EN = 1'b0;
    n_tests++;
    if (bus.STALL !== 1'b0) begin
      n_fail++;
      $display("FAIL reissue_after_wb: STALL=%b required 0", bus.STALL);
    end
    step();
    n_tests++;
    if (bus.STALL !== 1'b1) begin
      n_fail++;
      $display("FAIL reissue_accepted: STALL=%b required 1", bus.STALL);
    end
    bus.ISSUE_REQ = 1'b0; bus.WB_EN = 1'b1; bus.WB_DATA = 32'h45;
    step();
    bus.WB_EN = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.ISSUE_REQ = 1'b1; bus.RD = 5'd12;
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd13; bus.WB_DATA = 32'h1313;
    bus.RS1_ADDR = 5'd13; bus.RS2_ADDR = 5'd4;
    sbq.push_back('{BYP ? 32'h1313 : 32'h0, 32'h45});
    step();
    bus.WB_EN = 1'b0; bus.RS1_ADDR = 5'd0; bus.RS2_ADDR = 5'd0;
    e = sbq.pop_front();
    n_tests++;
    if (bus.STALL !== 1'b1 || bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL b2b: STALL=%b RS=%h/%h required 1 %h/%h", bus.STALL, bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
    bus.ISSUE_REQ = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.WB_EN = 1'b1; bus.WB_ADDR = 5'd9; bus.WB_DATA = 32'h3;
    step();
    bus.WB_EN = 1'b0; bus.ISSUE_REQ = 1'b1; bus.RD = 5'd9;
    step();
    bus.ISSUE_REQ = 1'b0; bus.RS1_ADDR = 5'd9; bus.RS2_ADDR = 5'd9;
    sbq.push_back('{32'h3, 32'h3});
    step();
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL arst_pre: got %h/%h required %h/%h", bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.RS1 !== 32'h0 || bus.RS2 !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_immediate: RS1=%h RS2=%h required 0 0", bus.RS1, bus.RS2);
    end
    #1 reset = 1'b0;
    bus.ISSUE_REQ = 1'b1; bus.RD = 5'd9; bus.RS1_ADDR = 5'd5; bus.RS2_ADDR = 5'd9;
    #1;
    n_tests++;
    if (bus.STALL !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_busy_cleared: STALL=%b required 0", bus.STALL);
    end
    sbq.push_back('{32'h0, 32'h0});
    step();
    bus.ISSUE_REQ = 1'b0;
    e = sbq.pop_front();
    n_tests++;
    if (bus.RS1 !== e.rs1 || bus.RS2 !== e.rs2) begin
      n_fail++;
      $display("FAIL arst_regs_cleared: got %h/%h required %h/%h", bus.RS1, bus.RS2, e.rs1, e.rs2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_stall();
    test_bypass();
    test_reissue();
    test_back_to_back();
    test_async_reset();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback register file and scoreboard for the 32-bit CPU. It sits directly downstream of the writeback select mux: it commits the selected writeback value (`WB_DATA`) into a 32 × 32-bit register file and returns registered operand reads to decode/issue. A per-register busy scoreboard tracks destinations with writes still in flight, and raises `STALL` when an issuing instruction depends on a pending result.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers. Address width is log2(`NREG`) = 5.
- `XLEN`, 32: data width.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `WB_EN` in 1: commit `WB_DATA` to `WB_ADDR` this cycle.
- `WB_ADDR` in 5: writeback destination register.
- `WB_DATA` in 32: writeback value, driven by the writeback mux output.
- `RS1_ADDR`, `RS2_ADDR` in 5: source operand addresses.
- `RS1`, `RS2` out 32: registered operand read data.
- `ISSUE_REQ` in 1: decode presents an instruction that writes `RD`.
- `RD` in 5: destination of the issuing instruction.
- `STALL` out 1: issue blocked this cycle (combinational).

## Operation
- Register file:
  - r0 reads as 0 at all times.
  - Writes to r0 are discarded and never set or clear busy.
- Write: on a rising edge with `WB_EN`=1 and `WB_ADDR`≠0, `RF[WB_ADDR]` ← `WB_DATA` and `busy[WB_ADDR]` ← 0.
- Read: on every rising edge, `RS1` ← `RF[RS1_ADDR]` and `RS2` ← `RF[RS2_ADDR]`, with r0 forced to 0.
- Stall logic:
  - `STALL` = `ISSUE_REQ` & (`busy[RS1_ADDR]` | `busy[RS2_ADDR]` | `busy[RD]`).
  - `busy[0]` is constant 0.
  - `STALL` uses the current busy state only. It does not look ahead to a writeback landing in the same cycle.
- Issue: on a rising edge with `ISSUE_REQ`=1, `STALL`=0 and `RD`≠0, `busy[RD]` ← 1.
  - Because `RD` is part of the stall check, at most one write per register is outstanding.
- Simultaneous issue and writeback on different registers: both take effect on the same edge.
- Simultaneous issue and writeback on the same register: cannot occur. `busy[RD]`=1 forces `STALL`, so the writeback clears busy and the issue retries next cycle.
- Writeback to a register that is not busy: data is written; busy stays 0. This is legal, e.g. for initialization.

## Timing
- Read latency: 1 cycle. The address is presented in cycle N; `RS1`/`RS2` are valid after the edge ending cycle N.
- Write visibility: a write committed at edge E appears on the read outputs at edge E+1 (see `WB_REGFILE_BYPASS_EN` for same-edge forwarding).
- `STALL`: combinational from `ISSUE_REQ`, the addresses and the busy state. No registered delay.
- Reset (asynchronous, takes effect immediately):
  - All registers → 0.
  - All busy bits → 0.
  - `RS1` = `RS2` = 0.
  - `STALL` = 0 while `ISSUE_REQ`=0.
- Reset asserted mid-operation discards all pending busy state. Writebacks arriving after reset deassertion simply write data.
- No internal pipeline: throughput is one write, two reads and one issue per cycle.

## Configuration
- `WB_REGFILE_BYPASS_EN` defined:
  - If `WB_EN`=1, `WB_ADDR`≠0 and `WB_ADDR`=`RS1_ADDR` at edge E, then `RS1` ← `WB_DATA` at E. The same applies to `RS2`.
  - The new value is visible with no extra cycle.
  - `STALL` also ignores `busy[x]` for a source x equal to a `WB_ADDR` being written this cycle. `busy[RD]` is not relaxed.
- Not defined:
  - Reads at edge E return the pre-write register contents.
  - `STALL` uses busy bits as-is.

## Test plan
- Reset, then write r5=0x0000_0011 (`WB_EN`=1) → next edge with `RS1_ADDR`=5 gives `RS1`=0x11; `RS2_ADDR`=0 gives `RS2`=0.
- Write r0=0xFFFF_FFFF → r0 still reads 0; `busy[0]` never set.
- Issue `RD`=3, then `ISSUE_REQ` with `RS1_ADDR`=3 → `STALL`=1.
  - After writeback r3=0x5, `STALL`=0 the following cycle.
  - With the macro defined, `STALL`=0 in the writeback cycle itself.
- Same-edge write r7=0xA and read `RS2_ADDR`=7 (r7 previously 0x2) → `RS2`=0x2 without the macro; 0xA with `WB_REGFILE_BYPASS_EN`.
- Issue `RD`=4 while r4 is busy → `STALL`=1 and busy unchanged; re-issue after writeback is accepted.
- Assert `reset` asynchronously mid-cycle with r9 busy and r9=0x3 → `RS1`, `RS2` and all registers go to 0 immediately; a following issue on r9 gives `STALL`=0.
